// File: rtl/reparam_sampler_pipeline.sv
// Reparameterization stage of the VAE datapath: z = mu + sigma * eps per
// latent lane. eps is an approximate standard-normal value built from the
// four nibbles of a per-lane 16-bit Galois LFSR (a sum of four uniforms).
// Three registered stages, one sample per cycle, no backpressure.
//
// Handshake: in_valid qualifies mu, sigma and eps_bypass in the same cycle.
// There is no ready, so every in_valid cycle is accepted. out_valid
// qualifies z exactly three edges later. z holds don't-care data while
// out_valid is low.
module reparam_sampler_pipeline #(
  parameter int          N_LATENT = 2,
  parameter int          BITSIZE  = 16,
  parameter int          FRAC     = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [N_LATENT*BITSIZE-1:0] mu,
  input  logic [N_LATENT*BITSIZE-1:0] sigma,
  input  logic                        eps_bypass,
  input  logic                        seed_load,
  input  logic [BITSIZE-1:0]          seed_in,
  output logic [N_LATENT*BITSIZE-1:0] z,
  output logic                        out_valid
);

  localparam logic signed [BITSIZE-1:0] SAT_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0] SAT_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

  // The LFSR is always 16 bits wide, whatever the datapath word width.
  logic [15:0] seed16;
  assign seed16 = 16'(seed_in);

  // Per-lane seed: decorrelate lanes with a lane-dependent XOR. An
  // all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] seed_lane(input logic [15:0] s, input int lane);
    logic [15:0] v;
    v = s ^ 16'(16'h0101 * lane);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Nibble sum is 0..60 with mean 30; scaling by 28 gives about +-3.28 in Q8.8.
  function automatic logic signed [BITSIZE-1:0] eps_of(input logic [15:0] s);
    logic [5:0]         sum;
    logic signed [11:0] e;
    sum = 6'(s[3:0]) + 6'(s[7:4]) + 6'(s[11:8]) + 6'(s[15:12]);
    e   = ($signed({6'b000000, sum}) - 12'sd30) * 12'sd28;
    return BITSIZE'(e);
  endfunction

  logic v1, v2;

  // Valid bits travel alongside the data; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  for (genvar i = 0; i < N_LATENT; i++) begin : g_lane
    logic [15:0]                 lfsr;
    logic signed [BITSIZE-1:0]   mu_s1, sig_s1, eps_s1;
    logic signed [BITSIZE-1:0]   mu_s2, prod_s2;
    logic signed [BITSIZE-1:0]   z_s3;
    logic signed [2*BITSIZE-1:0] prod_full, prod_shift;
    logic signed [BITSIZE-1:0]   prod_sat;
    logic signed [BITSIZE:0]     sum_w;
    logic signed [BITSIZE-1:0]   sum_sat;

    // LFSR: a seed load wins over the step; steps only on accepted samples.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          lfsr <= seed_lane(SEED, i);
      else if (seed_load) lfsr <= seed_lane(seed16, i);
      else if (in_valid)  lfsr <= lfsr_step(lfsr);
    end

    // Stage 1: capture operands and eps drawn from the pre-step LFSR state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mu_s1  <= '0;
        sig_s1 <= '0;
        eps_s1 <= '0;
      end else begin
        mu_s1  <= mu[i*BITSIZE +: BITSIZE];
        sig_s1 <= sigma[i*BITSIZE +: BITSIZE];
        eps_s1 <= eps_bypass ? '0 : eps_of(lfsr);
      end
    end

    // Stage 2 combinational: full product, floor shift back to Qx.FRAC, saturate.
    always_comb begin
      prod_full  = sig_s1 * eps_s1;
      prod_shift = prod_full >>> FRAC;
      if (prod_shift > SAT_MAX)      prod_sat = SAT_MAX;
      else if (prod_shift < SAT_MIN) prod_sat = SAT_MIN;
      else                           prod_sat = prod_shift[BITSIZE-1:0];
    end

    // Stage 2: register the scaled noise together with mu.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mu_s2   <= '0;
        prod_s2 <= '0;
      end else begin
        mu_s2   <= mu_s1;
        prod_s2 <= prod_sat;
      end
    end

    // Stage 3 combinational: one-bit-wider add so overflow is visible, then saturate.
    always_comb begin
      sum_w = {mu_s2[BITSIZE-1], mu_s2} + {prod_s2[BITSIZE-1], prod_s2};
      if (sum_w > SAT_MAX)      sum_sat = SAT_MAX;
      else if (sum_w < SAT_MIN) sum_sat = SAT_MIN;
      else                      sum_sat = sum_w[BITSIZE-1:0];
    end

    // Stage 3: output register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) z_s3 <= '0;
      else       z_s3 <= sum_sat;
    end

    assign z[i*BITSIZE +: BITSIZE] = z_s3;
  end

endmodule

// File: tb/tb_reparam_sampler_pipeline.sv
// Self-checking bench for reparam_sampler_pipeline (default parameters).
// Known vectors are pushed as fixed expected values; random traffic uses a
// small bench-side model of the LFSR and fixed-point arithmetic.
module tb_reparam_sampler_pipeline;

  localparam int NL = 2;
  localparam int B  = 16;
  localparam int W  = NL * B;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  mu = '0;
  logic [W-1:0]  sigma = '0;
  logic          eps_bypass = 1'b0;
  logic          seed_load = 1'b0;
  logic [B-1:0]  seed_in = '0;
  logic [W-1:0]  z;
  logic          out_valid;

  always #5 clk = ~clk;

  reparam_sampler_pipeline #(
    .N_LATENT(NL), .BITSIZE(B), .FRAC(8), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mu(mu), .sigma(sigma),
    .eps_bypass(eps_bypass), .seed_load(seed_load), .seed_in(seed_in),
    .z(z), .out_valid(out_valid)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  lf [NL];
  logic [2:0]   exp_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] tb_seed(input logic [15:0] s, input int i);
    logic [15:0] v;
    v = s ^ 16'(16'h0101 * i);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] tb_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int tb_eps(input logic [15:0] s);
    int sum;
    sum = int'(s[3:0]) + int'(s[7:4]) + int'(s[11:8]) + int'(s[15:12]);
    return (sum - 30) * 28;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] tb_lane(input logic signed [15:0] m,
                                          input logic signed [15:0] sg,
                                          input int e);
    int p;
    p = clamp16((int'(sg) * e) >>> 8);
    return 16'(clamp16(int'(m) + p));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) lf[i] = tb_seed(16'hACE1, i);
  endtask

  // Output-valid pipeline model, cleared by reset like the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_v <= 3'b000;
    else       exp_v <= {exp_v[1:0], in_valid};
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v[2]});
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'd0);
        else                   check("z", z, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] m, input logic [W-1:0] s,
                      input logic byp, input logic sld, input logic [15:0] sin,
                      input logic use_fixed, input logic [W-1:0] fixed);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid   = 1'b1;
    mu         = m;
    sigma      = s;
    eps_bypass = byp;
    seed_load  = sld;
    seed_in    = sin;
    for (int i = 0; i < NL; i++)
      e[i*B +: B] = tb_lane(m[i*B +: B], s[i*B +: B], byp ? 0 : tb_eps(lf[i]));
    exp_q.push_back(use_fixed ? fixed : e);
    for (int i = 0; i < NL; i++)
      lf[i] = sld ? tb_seed(sin, i) : tb_step(lf[i]);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      seed_load  = 1'b0;
      eps_bypass = 1'b0;
      mu         = W'($urandom);
      sigma      = W'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    seed_load = 1'b0;
    reset     = 1'b1;
    #1;
    check("reset_z", z, '0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    check("por_z", z, '0);
    check("por_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // eps values straight after reset: sigma=1.0, mu=0
    send({16'h0000, 16'h0000}, {16'h0100, 16'h0100}, 0, 0, 0, 1, {16'h00C4, 16'h00C4});
    send({16'h0000, 16'h0000}, {16'h0100, 16'h0100}, 0, 0, 0, 1, {16'hFF90, 16'hFF3C});
    drain();

    // reset with three samples in flight: none may emerge afterwards
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    do_reset();
    idle(6);

    // positive saturation on the first sample after reset
    send({16'h0000, 16'h7F00}, {16'h0100, 16'h7FFF}, 0, 0, 0, 1, {16'h00C4, 16'h7FFF});
    drain();
    do_reset();
    // negative saturation mirror
    send({16'h0000, 16'h8100}, {16'h0100, 16'h8001}, 0, 0, 0, 1, {16'h00C4, 16'h8000});
    drain();

    // bypass: z equals mu regardless of sigma
    send({16'h1234, 16'h0180}, {16'h4000, 16'h7FFF}, 1, 0, 0, 1, {16'h1234, 16'h0180});
    drain();

    // valid gaps 1,1,0,1
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    idle(1);
    send(W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
    drain();

    // seed load with concurrent sample: old state used, zero-seed rule on lane 0
    do_reset();
    send({16'h0000, 16'h0000}, {16'h0100, 16'h0100}, 0, 1, 16'h0000, 1, {16'h00C4, 16'h00C4});
    send({16'h0000, 16'h0000}, {16'h0100, 16'h0100}, 0, 0, 0, 1, {16'hFCF0, 16'hFCD4});
    drain();

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0)
        idle(1);
      else
        send(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 15) == 0), 16'($urandom), 0, '0);
    end
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
